serial_p2s_ctrl: RTL and testbench

//  Parallel-to-serial driver placed directly downstream of the 32-bit display-data shift stage.

---
 rtl/serial_p2s_ctrl_pkg.sv | 17 +
 rtl/serial_p2s_ctrl_if.sv | 26 ++
 rtl/serial_p2s_ctrl_clk_div.sv | 26 ++
 rtl/serial_p2s_ctrl.sv | 104 ++++++++++
 tb/tb_serial_p2s_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_p2s_ctrl_pkg.sv
// Shared definitions for the parallel-to-serial LED/7-seg chain driver.
// Holds the FSM state encoding and the default frame/divider sizes.
package p2s_pkg;

    localparam int P2S_DATA_W_DEF = 32;
    localparam int P2S_DIV_DEF    = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SLO   = 3'd2,
        S_SHI   = 3'd3,
        S_LATCH = 3'd4,
        S_DONE  = 3'd5
    } p2s_state_t;

endpackage

// File: rtl/serial_p2s_ctrl_if.sv
// Producer handshake plus external serial-chain pins of serial_p2s_ctrl.
// master: start, PData out / status, chain pins in. slave: the reverse.
interface serial_p2s_ctrl_if #(
    parameter int DATA_W = 32
) ();

    logic              start;
    logic [DATA_W-1:0] PData;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              sdata;
    logic              slatch;
    logic              sclrn;

    modport master (
        output start, PData,
        input  busy, done, sclk, sdata, slatch, sclrn
    );

    modport slave (
        input  start, PData,
        output busy, done, sclk, sdata, slatch, sclrn
    );

endinterface

// File: rtl/serial_p2s_ctrl_clk_div.sv
// Dwell-time tick generator: counts modulo DIV, restarts on request.
// Ports: clk, clear (sync high), restart (sync), tick (last count of window).
module p2s_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    localparam logic [DIV-1:0] LAST = DIV'(DIV - 1);

    logic [DIV-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clear || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_p2s_ctrl.sv
// Captures a word on start and shifts it out with sclk, then pulses slatch.
// Ports: clk, clear (sync high), bus (slave: start/PData in, status+chain out).
// Build option: define P2S_LSB_FIRST_EN to send PData[0] first (default MSB).
module serial_p2s_ctrl
    import p2s_pkg::*;
#(
    parameter int DATA_W = P2S_DATA_W_DEF,
    parameter int DIV    = P2S_DIV_DEF
) (
    input  logic             clk,
    input  logic             clear,
    serial_p2s_ctrl_if.slave bus
);

    localparam int CW = $clog2(DATA_W + 1);

    p2s_state_t        state;
    p2s_state_t        state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic [CW-1:0]     cnt;
    logic              head;
    logic              next_bit;
    logic              tick;
    logic              restart;
    logic              sdata_q;
    logic              sclrn_q;

    always_comb begin
`ifdef P2S_LSB_FIRST_EN
        shifted  = {1'b0, shreg[DATA_W-1:1]};
        head     = shreg[0];
        next_bit = shifted[0];
`else
        shifted  = {shreg[DATA_W-2:0], 1'b0};
        head     = shreg[DATA_W-1];
        next_bit = shifted[DATA_W-1];
`endif
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_next = S_LOAD;
            S_LOAD:  state_next = S_SLO;
            S_SLO:   if (tick) state_next = S_SHI;
            S_SHI: begin
                if (tick) begin
                    state_next = (cnt == CW'(1)) ? S_LATCH : S_SLO;
                end
            end
            S_LATCH: if (tick) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Every state change restarts the dwell window.
    assign restart = (state_next != state);

    p2s_clk_div #(
        .DIV(DIV)
    ) u_div (
        .clk    (clk),
        .clear  (clear),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            sdata_q <= 1'b0;
            sclrn_q <= 1'b0;
        end else begin
            state   <= state_next;
            sclrn_q <= 1'b1;
            if (state == S_IDLE && bus.start) begin
                shreg <= bus.PData;
                cnt   <= CW'(DATA_W);
            end
            if (state == S_LOAD) begin
                sdata_q <= head;
            end
            // Data moves only as sclk falls, so it holds through sclk high.
            if (state == S_SHI && tick) begin
                shreg   <= shifted;
                cnt     <= cnt - 1'b1;
                sdata_q <= next_bit;
            end
        end
    end

    assign bus.busy   = (state == S_LOAD) || (state == S_SLO) ||
                        (state == S_SHI)  || (state == S_LATCH);
    assign bus.done   = (state == S_DONE);
    assign bus.sclk   = (state == S_SHI);
    assign bus.slatch = (state == S_LATCH);
    assign bus.sdata  = sdata_q;
    assign bus.sclrn  = sclrn_q;

endmodule

// File: tb/tb_serial_p2s_ctrl.sv
// Randomised scoreboard bench for serial_p2s_ctrl (32/2 and 8/1 instances).
// Accepted frames are queued by a frame-level model; a monitor checks the pins.
module tb_serial_p2s_ctrl;
    import p2s_pkg::*;

    localparam int DW  = P2S_DATA_W_DEF;
    localparam int DV  = P2S_DIV_DEF;
    localparam int LAT = 1 + 2 * DV * DW + DV;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } frame_t;

    logic clk = 1'b0;
    logic clear;
    logic clear2;

    always #5 clk = ~clk;

    serial_p2s_ctrl_if #(.DATA_W(DW)) bus ();
    serial_p2s_ctrl_if #(.DATA_W(8))  bus2 ();

    serial_p2s_ctrl #(.DATA_W(DW), .DIV(DV)) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    serial_p2s_ctrl #(.DATA_W(8), .DIV(1)) dut2 (
        .clk  (clk),
        .clear(clear2),
        .bus  (bus2)
    );

    frame_t q[$];
    int     cyc     = 0;
    int     free_at = 0;
    int     checks  = 0;
    int     errors  = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] d, input int i);
`ifdef P2S_LSB_FIRST_EN
        return d[i];
`else
        return d[DW-1-i];
`endif
    endfunction

    // Frame-level model: a start is taken once the previous frame's
    // DONE and one IDLE cycle are over; clear discards everything.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (clear) begin
            q.delete();
            free_at = cyc + 1;
        end else if (bus.start && cyc >= free_at) begin
            q.push_back('{bus.PData, cyc});
            free_at = cyc + LAT + 2;
        end
    end

    int   bidx  = 0;
    int   lcnt  = 0;
    logic psclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (clear) begin
            bidx  = 0;
            lcnt  = 0;
            psclk = 1'b0;
        end else begin
            if (bus.sclk && !psclk) begin
                if (q.size() == 0 || bidx >= DW) begin
                    check("spurious_sclk", 1, 0);
                end else begin
                    check("sdata", bus.sdata, exp_bit(q[0].data, bidx));
                    check("busy_shift", bus.busy, 1);
                    bidx++;
                end
            end
            if (bus.slatch) begin
                if (q.size() == 0 || bidx != DW) begin
                    check("early_latch", 1, 0);
                end
                check("sclk_in_latch", bus.sclk, 0);
                lcnt++;
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    check("done_cycle", cyc - q[0].acc, LAT);
                    check("bit_count", bidx, DW);
                    check("latch_width", lcnt, DV);
                    check("busy_at_done", bus.busy, 0);
                    void'(q.pop_front());
                end
                bidx = 0;
                lcnt = 0;
            end
            psclk = bus.sclk;
        end
    end

    int         d2_rises  = 0;
    int         d2_last   = 0;
    int         d2_frames = 0;
    logic [7:0] d2_bits   = '0;
    logic       ps2       = 1'b0;
    logic [7:0] d2_word   = 8'hC3;

    always @(posedge clk) begin
        #1;
        if (!clear2) begin
            if (bus2.sclk && !ps2) begin
                d2_rises++;
`ifdef P2S_LSB_FIRST_EN
                d2_bits = {bus2.sdata, d2_bits[7:1]};
`else
                d2_bits = {d2_bits[6:0], bus2.sdata};
`endif
            end
            if (bus2.done) begin
                if (d2_frames < 4) begin
                    check("d2_rises", d2_rises, 8);
                    check("d2_bits", d2_bits, d2_word);
                    check("d2_period", cyc - d2_last, 20);
                end
                d2_frames++;
                d2_last  = cyc;
                d2_rises = 0;
            end
            ps2 = bus2.sclk;
        end
    end

    task automatic send(input logic [DW-1:0] d);
        bus.PData = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("frame_timeout", 1, 0);
            q.delete();
        end
    endtask

    initial begin
        repeat (50000) @(negedge clk);
        $display("FAIL watchdog: got no end expected end by 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start  = 1'b0;
        bus.PData  = '0;
        bus2.start = 1'b0;
        bus2.PData = 8'h00;
        clear      = 1'b1;
        clear2     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sclk", bus.sclk, 0);
        check("rst_sdata", bus.sdata, 0);
        check("rst_slatch", bus.slatch, 0);
        check("rst_sclrn", bus.sclrn, 0);
        clear      = 1'b0;
        clear2     = 1'b0;
        bus2.start = 1'b1;
        bus2.PData = 8'hC3;
        d2_last    = cyc - 1;
        @(negedge clk);
        check("sclrn_release", bus.sclrn, 1);

        send(32'h8000_0001);
        wait_idle(LAT + 20);
        send(32'h0000_0003);
        wait_idle(LAT + 20);

        send(32'hA5A5_A5A5);
        bus.PData = '0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(5, 25)) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle(LAT + 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("no_restart_in_done", q.size(), 0);

        send($urandom);
        n = 0;
        while (bidx < 10 && n < LAT) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit10", bidx, 10);
        clear = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_sclk", bus.sclk, 0);
        check("abort_sdata", bus.sdata, 0);
        check("abort_sclrn", bus.sclrn, 0);
        check("abort_slatch", bus.slatch, 0);
        check("abort_done", bus.done, 0);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        send($urandom);
        wait_idle(LAT + 20);

        clear     = 1'b1;
        bus.start = 1'b1;
        bus.PData = $urandom;
        @(negedge clk);
        check("sc_busy", bus.busy, 0);
        clear     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("sc_idle", bus.busy, 0);
        repeat (10) @(negedge clk);

        bus.PData = $urandom;
        bus.start = 1'b1;
        repeat (2 * (LAT + 2) + 1) @(negedge clk);
        bus.start = 1'b0;
        wait_idle(LAT + 20);

        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            send($urandom);
            wait_idle(LAT + 20);
        end

        repeat (4) @(negedge clk);
        check("d2_frame_count", d2_frames >= 4, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
